// File: rtl/code_loader_pkg.sv
// code_loader_pkg: shared types and constants for the code memory loader.
// Holds the loader state enum, the frame start byte, the length field width
// and the 3-byte little-endian code word layout.
// Build option: CODE_LOADER_CSUM_EN adds the checksum state to the enum.
package code_loader_pkg;

  localparam logic [7:0]  LOADER_START_BYTE = 8'hA5;
  localparam int unsigned LOADER_LEN_W      = 18;

  // Loader states; CSUM exists only when the frame carries a checksum byte.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_LEN2,
    ST_DATA0,
    ST_DATA1,
    ST_DATA2,
`ifdef CODE_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_RUN,
    ST_ERR
  } loader_state_t;

  // 18-bit code word as carried in the byte stream: {b2[1:0], b1, b0}.
  typedef struct packed {
    logic [1:0] hi;
    logic [7:0] mid;
    logic [7:0] lo;
  } code_word_t;

endpackage

// File: rtl/code_ram.sv
// code_ram: MEM_SIZE x WORD_SIZE code memory.
// One synchronous write port, one asynchronous read port; reads at or beyond
// MEM_SIZE return zero. Contents are never cleared by reset.
// Ports:
//   clock    in   write clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata_c  out  combinational read data
module code_ram #(
  parameter int unsigned ADDR_SIZE = 18,
  parameter int unsigned WORD_SIZE = 18,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [WORD_SIZE-1:0] rdata_c
);

  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  // Write port; out-of-range addresses are dropped.
  always_ff @(posedge clock) begin
    if (we && (32'(waddr) < MEM_SIZE)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Fetch port; out-of-range addresses read as zero.
  always_comb begin
    rdata_c = '0;
    if (32'(raddr) < MEM_SIZE) begin
      rdata_c = mem[raddr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/code_loader.sv
// code_loader: code memory for the 18-bit processor plus a byte-stream
// program loader. Frame: A5, 3-byte LE length N, N words of 3 LE bytes
// ({b2[1:0], b1, b0}), then an XOR checksum of length and data bytes when
// CODE_LOADER_CSUM_EN is defined. The processor is held in reset until a
// load completes successfully.
// Build option: CODE_LOADER_CSUM_EN enables the checksum byte and CSUM state.
// Ports:
//   clock       in   clock
//   reset       in   async active-low reset
//   code_addr   in   processor fetch address
//   code_word   out  combinational fetch data (0 when out of range)
//   in_data     in   loader byte
//   in_valid    in   loader byte valid
//   in_ready    out  loader accepts a byte (1 whenever out of reset)
//   cpu_reset   out  active-high processor reset
//   loaded      out  last load succeeded
//   load_error  out  last load failed
//   word_count  out  words written by the current/last load
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 18,
  parameter int unsigned WORD_SIZE = 18,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] code_addr,
  output logic [WORD_SIZE-1:0] code_word,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 cpu_reset,
  output logic                 loaded,
  output logic                 load_error,
  output logic [ADDR_SIZE-1:0] word_count
);

  loader_state_t state_q, state_d;

  logic [LOADER_LEN_W-1:0] len_q, len_d;
  logic [7:0]              lo_q, lo_d;
  logic [7:0]              mid_q, mid_d;
  logic [ADDR_SIZE-1:0]    wc_q, wc_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    loaded_q, loaded_d;
  logic                    load_error_q, load_error_d;
  logic                    in_ready_q;
`ifdef CODE_LOADER_CSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic                    accept_c;
  logic                    we_c;
  logic [WORD_SIZE-1:0]    wdata_c;
  logic [LOADER_LEN_W-1:0] len_full_c;
  logic [ADDR_SIZE-1:0]    wc_inc_c;
  code_word_t              word_c;

  assign accept_c   = in_valid && in_ready_q;
  assign len_full_c = {in_data[1:0], len_q[15:0]};
  assign wc_inc_c   = wc_q + ADDR_SIZE'(1);

  assign word_c.hi  = in_data[1:0];
  assign word_c.mid = mid_q;
  assign word_c.lo  = lo_q;
  assign wdata_c    = WORD_SIZE'(word_c);

  // Next-state, byte assembly, counter and status decisions.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    lo_d         = lo_q;
    mid_d        = mid_q;
    wc_d         = wc_q;
    cpu_reset_d  = cpu_reset_q;
    loaded_d     = loaded_q;
    load_error_d = load_error_q;
    we_c         = 1'b0;
`ifdef CODE_LOADER_CSUM_EN
    csum_d       = csum_q;
`endif

    if (accept_c) begin
      case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (in_data == LOADER_START_BYTE) begin
            state_d      = ST_LEN0;
            cpu_reset_d  = 1'b1;
            loaded_d     = 1'b0;
            load_error_d = 1'b0;
            wc_d         = '0;
`ifdef CODE_LOADER_CSUM_EN
            csum_d       = 8'h00;
`endif
          end
        end
        ST_LEN0: begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN1;
`ifdef CODE_LOADER_CSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
        end
        ST_LEN1: begin
          len_d[15:8] = in_data;
          state_d     = ST_LEN2;
`ifdef CODE_LOADER_CSUM_EN
          csum_d      = csum_q ^ in_data;
`endif
        end
        ST_LEN2: begin
          len_d = len_full_c;
`ifdef CODE_LOADER_CSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (32'(len_full_c) > MEM_SIZE) begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
          end else if (len_full_c == '0) begin
`ifdef CODE_LOADER_CSUM_EN
            state_d     = ST_CSUM;
`else
            state_d     = ST_RUN;
            loaded_d    = 1'b1;
            cpu_reset_d = 1'b0;
`endif
          end else begin
            state_d = ST_DATA0;
          end
        end
        ST_DATA0: begin
          lo_d    = in_data;
          state_d = ST_DATA1;
`ifdef CODE_LOADER_CSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
        end
        ST_DATA1: begin
          mid_d   = in_data;
          state_d = ST_DATA2;
`ifdef CODE_LOADER_CSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
        end
        ST_DATA2: begin
          we_c = 1'b1;
          wc_d = wc_inc_c;
`ifdef CODE_LOADER_CSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (wc_inc_c == ADDR_SIZE'(len_q)) begin
`ifdef CODE_LOADER_CSUM_EN
            state_d     = ST_CSUM;
`else
            state_d     = ST_RUN;
            loaded_d    = 1'b1;
            cpu_reset_d = 1'b0;
`endif
          end else begin
            state_d = ST_DATA0;
          end
        end
`ifdef CODE_LOADER_CSUM_EN
        ST_CSUM: begin
          if (in_data == csum_q) begin
            state_d     = ST_RUN;
            loaded_d    = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      lo_q         <= '0;
      mid_q        <= '0;
      wc_q         <= '0;
      cpu_reset_q  <= 1'b1;
      loaded_q     <= 1'b0;
      load_error_q <= 1'b0;
      in_ready_q   <= 1'b0;
`ifdef CODE_LOADER_CSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      lo_q         <= lo_d;
      mid_q        <= mid_d;
      wc_q         <= wc_d;
      cpu_reset_q  <= cpu_reset_d;
      loaded_q     <= loaded_d;
      load_error_q <= load_error_d;
      in_ready_q   <= 1'b1;
`ifdef CODE_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign cpu_reset  = cpu_reset_q;
  assign loaded     = loaded_q;
  assign load_error = load_error_q;
  assign word_count = wc_q;

  code_ram #(
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE),
    .MEM_SIZE  (MEM_SIZE)
  ) u_code_ram (
    .clock   (clock),
    .we      (we_c),
    .waddr   (wc_q),
    .wdata   (wdata_c),
    .raddr   (code_addr),
    .rdata_c (code_word)
  );

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: self-checking bench for code_loader. Builds frames from
// word lists, drives them byte by byte (optionally with idle gaps), and
// compares status outputs and memory contents against a frame-level model.
module tb_code_loader;
  import code_loader_pkg::*;

  localparam int unsigned ADDR_SIZE = 18;
  localparam int unsigned WORD_SIZE = 18;
  localparam int unsigned MEM_SIZE  = 1024;
`ifdef CODE_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic [ADDR_SIZE-1:0] code_addr;
  logic [WORD_SIZE-1:0] code_word;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 cpu_reset;
  logic                 loaded;
  logic                 load_error;
  logic [ADDR_SIZE-1:0] word_count;

  code_loader #(
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE),
    .MEM_SIZE  (MEM_SIZE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .code_addr  (code_addr),
    .code_word  (code_word),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cpu_reset  (cpu_reset),
    .loaded     (loaded),
    .load_error (load_error),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [17:0] mmem [MEM_SIZE];
  bit          mval [MEM_SIZE];
  bit          exp_loaded, exp_err, exp_cpu_reset;
  int          exp_wc;
  logic [17:0] fw [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_ready);
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'(exp_cpu_reset));
    check({tag, "_loaded"},     32'(loaded),     32'(exp_loaded));
    check({tag, "_load_error"}, 32'(load_error), 32'(exp_err));
    check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
    check({tag, "_in_ready"},   32'(in_ready),   32'(exp_ready));
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < int'(MEM_SIZE); i++) begin
      if (mval[i]) begin
        code_addr = 18'(i);
        #1;
        check($sformatf("%s_mem%0d", tag, i), 32'(code_word), 32'(mmem[i]));
      end
    end
  endtask

  // One byte, optionally preceded by idle cycles carrying junk data.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pre_chk);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    if (pre_chk) check("pre_final_cpu_reset", 32'(cpu_reset), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Send a frame for the words in fw, then advance the model.
  task automatic send_frame(input logic [17:0] n, input bit bad, input bit gaps,
                            input bit skip_start, input logic [7:0] len2_hi);
    logic [7:0] cs;
    logic [7:0] b;
    bit         too_long;
    too_long = (n > 18'(MEM_SIZE));
    cs = 8'h00;
    if (!skip_start) send_byte(LOADER_START_BYTE, gaps, 1'b0);
    b = n[7:0];   cs ^= b; send_byte(b, gaps, 1'b0);
    b = n[15:8];  cs ^= b; send_byte(b, gaps, 1'b0);
    b = {len2_hi[7:2], n[17:16]}; cs ^= b;
    send_byte(b, gaps, too_long || (n == 0 && !CSUM_EN));
    if (!too_long) begin
      for (int i = 0; i < int'(n); i++) begin
        b = fw[i][7:0];  cs ^= b; send_byte(b, gaps, 1'b0);
        b = fw[i][15:8]; cs ^= b; send_byte(b, gaps, 1'b0);
        b = {(gaps ? 6'($urandom) : 6'd0), fw[i][17:16]}; cs ^= b;
        send_byte(b, gaps, (i == int'(n) - 1) && !CSUM_EN);
      end
      if (CSUM_EN) send_byte(cs ^ {7'd0, bad}, gaps, 1'b1);
    end
    // Model: outcome of the whole frame.
    if (too_long) begin
      exp_err = 1'b1; exp_loaded = 1'b0; exp_cpu_reset = 1'b1; exp_wc = 0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        mmem[i] = fw[i];
        mval[i] = 1'b1;
      end
      exp_wc = int'(n);
      if (bad && CSUM_EN) begin
        exp_err = 1'b1; exp_loaded = 1'b0; exp_cpu_reset = 1'b1;
      end else begin
        exp_err = 1'b0; exp_loaded = 1'b1; exp_cpu_reset = 1'b0;
      end
    end
  endtask

  task automatic fill_random(input int n);
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back(18'($urandom));
  endtask

  task automatic send_junk(input int count);
    logic [7:0] j;
    for (int i = 0; i < count; i++) begin
      j = 8'($urandom);
      if (j == LOADER_START_BYTE) j = 8'h5A;
      send_byte(j, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < int'(MEM_SIZE); i++) begin
      mval[i] = 1'b0;
      mmem[i] = '0;
    end
    exp_loaded = 1'b0; exp_err = 1'b0; exp_cpu_reset = 1'b1; exp_wc = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    code_addr = '0;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_outputs("reset", 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_outputs("after_reset", 1'b1);

    // Directed frame from the reference example.
    fw = '{18'h11234, 18'h3FFFF};
    send_frame(18'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    check_outputs("frame_a", 1'b1);
    check_mem("frame_a");

    // A5 bytes inside the data are plain data.
    fw = '{18'h1A5A5};
    send_frame(18'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_outputs("a5_data", 1'b1);
    check_mem("a5_data");

`ifdef CODE_LOADER_CSUM_EN
    // Corrupted checksum, then recovery with a good frame.
    fw = '{18'h11234, 18'h3FFFF};
    send_frame(18'd2, 1'b1, 1'b0, 1'b0, 8'h00);
    check_outputs("bad_csum", 1'b1);
    send_junk(3);
    check_outputs("bad_csum_junk", 1'b1);
    fill_random(3);
    send_frame(18'd3, 1'b0, 1'b1, 1'b0, 8'h00);
    check_outputs("recover", 1'b1);
    check_mem("recover");
`endif

    // Largest legal length.
    fill_random(int'(MEM_SIZE));
    send_frame(18'(MEM_SIZE), 1'b0, 1'b0, 1'b0, 8'h00);
    check_outputs("len_max", 1'b1);
    check_mem("len_max");

    // One past the limit: error after the length, no writes.
    send_frame(18'(MEM_SIZE + 1), 1'b0, 1'b0, 1'b0, 8'h00);
    check_outputs("len_over", 1'b1);
    send_junk(6);
    check_outputs("len_over_junk", 1'b1);
    check_mem("len_over");

    // Empty program.
    fw.delete();
    send_frame(18'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_outputs("len_zero", 1'b1);
    check_mem("len_zero");

    // Out-of-range fetches read zero.
    code_addr = 18'h3FFFF; #1;
    check("fetch_3ffff", 32'(code_word), 32'd0);
    code_addr = 18'(MEM_SIZE); #1;
    check("fetch_memsize", 32'(code_word), 32'd0);

    // Randomized frames with junk before, idle gaps and ignored length bits.
    for (int k = 0; k < 8; k++) begin
      send_junk(int'($urandom_range(0, 3)));
      fill_random(int'($urandom_range(1, 20)));
      send_frame(18'(fw.size()), 1'b0, 1'b1, 1'b0, {6'($urandom), 2'b00});
      check_outputs($sformatf("rand%0d", k), 1'b1);
    end
    check_mem("rand");

    // Reset while collecting DATA1 of the second word.
    fw = '{18'h2BEEF, 18'h15555};
    send_byte(LOADER_START_BYTE, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(fw[0][7:0], 1'b0, 1'b0);
    send_byte(fw[0][15:8], 1'b0, 1'b0);
    send_byte({6'd0, fw[0][17:16]}, 1'b0, 1'b0);
    mmem[0] = fw[0];
    send_byte(fw[1][7:0], 1'b0, 1'b0);
    exp_loaded = 1'b0; exp_err = 1'b0; exp_cpu_reset = 1'b1; exp_wc = 1;
    check_outputs("mid_load", 1'b1);
    reset = 1'b0;
    #1;
    exp_wc = 0;
    check_outputs("abort_reset", 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_outputs("abort_release", 1'b1);
    send_byte(fw[1][15:8] == LOADER_START_BYTE ? 8'h00 : fw[1][15:8], 1'b0, 1'b0);
    check_outputs("abort_idle", 1'b1);
    check_mem("abort");

    // Good load, then a restart from RUN.
    fill_random(4);
    send_frame(18'd4, 1'b0, 1'b1, 1'b0, 8'h00);
    check_outputs("pre_restart", 1'b1);
    send_byte(LOADER_START_BYTE, 1'b0, 1'b0);
    exp_loaded = 1'b0; exp_err = 1'b0; exp_cpu_reset = 1'b1; exp_wc = 0;
    check_outputs("restart", 1'b1);
    fill_random(2);
    send_frame(18'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    check_outputs("restart_done", 1'b1);
    check_mem("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
